// File: rtl/pulse_arb.sv
// rtl/pulse_arb.sv - rate-limited round-robin arbiter feeding a shared pulse-crossing channel
//
// Ports:
//   XRST      in   asynchronous active-high reset
//   CLK_I     in   clock (single domain)
//   EN_I      in   issue enable; requests keep accumulating while low
//   REQ_I     in   [3:0] per-requester single-cycle events
//   CLR_OVF_I in   clears the sticky overflow flags
//   PULSE_O   out  one-cycle grant pulse into the toggle-based crossing channel
//   ID_O      out  [1:0] index of the most recent grant, held until the next one
//   PEND_O    out  [3:0] pending flags
//   OVF_O     out  [3:0] sticky overflow flags
//   BUSY_O    out  high while in GAP or anything is pending

module pulse_arb #(
  parameter int P_GAP = 8
) (
  input  logic       XRST,
  input  logic       CLK_I,
  input  logic       EN_I,
  input  logic [3:0] REQ_I,
  input  logic       CLR_OVF_I,
  output logic       PULSE_O,
  output logic [1:0] ID_O,
  output logic [3:0] PEND_O,
  output logic [3:0] OVF_O,
  output logic       BUSY_O
);

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  // CNT is loaded with P_GAP-1 on an issue so that, counting the issue edge
  // itself, the next issue edge lands exactly P_GAP cycles later.
  localparam logic [7:0] GAP_RELOAD = 8'(P_GAP - 1);

  state_t     state, state_n;
  logic [1:0] rr, rr_n;
  logic [7:0] cnt, cnt_n;

  logic       pulse_n;
  logic [1:0] id_n;
  logic [3:0] pend_n;
  logic [3:0] ovf_n;
  logic [3:0] ovf_set;
  logic [3:0] grant_mask;
  logic       busy_n;
  logic       issue;

  logic       found;
  logic [1:0] sel;
  logic [1:0] idx;

  // Round-robin pick: first pending requester starting at RR, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    sel   = rr;
    idx   = rr;
    for (int k = 0; k < 4; k++) begin
      idx = rr + 2'(k);
      if (!found && PEND_O[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rr_n       = rr;
    id_n       = ID_O;
    pulse_n    = 1'b0;
    grant_mask = 4'b0000;
    issue      = 1'b0;

    case (state)
      IDLE: begin
        issue = EN_I && found;
      end
      GAP: begin
        // A falling EN_I never shortens the gap; it only blocks the issue at its end.
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else if (EN_I && found) begin
          issue = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
    endcase

    if (issue) begin
      pulse_n    = 1'b1;
      id_n       = sel;
      grant_mask = 4'b0001 << sel;
      rr_n       = sel + 2'd1;
      cnt_n      = GAP_RELOAD;
      state_n    = GAP;
    end

    // A request landing on its own grant edge re-arms PEND without counting
    // as an overflow; otherwise a repeat while pending is merged and flagged.
    ovf_set = REQ_I & PEND_O & ~grant_mask;
    pend_n  = (PEND_O & ~grant_mask) | REQ_I;
    ovf_n   = CLR_OVF_I ? ovf_set : (OVF_O | ovf_set);
    busy_n  = (state_n != IDLE) || (pend_n != 4'b0000);
  end

  always_ff @(posedge CLK_I or posedge XRST) begin
    if (XRST) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      rr      <= 2'd0;
      PULSE_O <= 1'b0;
      ID_O    <= 2'd0;
      PEND_O  <= 4'b0000;
      OVF_O   <= 4'b0000;
      BUSY_O  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rr      <= rr_n;
      PULSE_O <= pulse_n;
      ID_O    <= id_n;
      PEND_O  <= pend_n;
      OVF_O   <= ovf_n;
      BUSY_O  <= busy_n;
    end
  end

endmodule

// File: tb/tb_pulse_arb.sv
// tb/tb_pulse_arb.sv - self-checking bench for pulse_arb
`timescale 1ns/1ps
module tb_pulse_arb;

  localparam int P_GAP = 8;

  logic       XRST;
  logic       CLK_I;
  logic       EN_I;
  logic [3:0] REQ_I;
  logic       CLR_OVF_I;
  logic       PULSE_O;
  logic [1:0] ID_O;
  logic [3:0] PEND_O;
  logic [3:0] OVF_O;
  logic       BUSY_O;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: pending/overflow sets plus "earliest cycle the next
  // issue may happen", counted in absolute clock edges.
  logic [3:0] m_pend;
  logic [3:0] m_ovf;
  logic [1:0] m_id;
  logic       m_pulse;
  logic       m_busy;
  int         m_rr;
  int         m_t;
  int         m_next_ok;

  pulse_arb #(.P_GAP(P_GAP)) dut (
    .XRST      (XRST),
    .CLK_I     (CLK_I),
    .EN_I      (EN_I),
    .REQ_I     (REQ_I),
    .CLR_OVF_I (CLR_OVF_I),
    .PULSE_O   (PULSE_O),
    .ID_O      (ID_O),
    .PEND_O    (PEND_O),
    .OVF_O     (OVF_O),
    .BUSY_O    (BUSY_O)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  // Toggle-based crossing channel into a clock at 1/4 of CLK_I.
  logic clk_o = 1'b0;
  initial begin
    #3;
    forever #20 clk_o = ~clk_o;
  end

  logic tog = 1'b0;
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int   grant_cnt = 0;
  int   out_cnt   = 0;

  always @(posedge CLK_I) begin
    if (PULSE_O) begin
      tog       <= ~tog;
      grant_cnt <= grant_cnt + 1;
    end
  end

  always @(posedge clk_o) begin
    s1 <= tog;
    s2 <= s1;
    s3 <= s2;
    if (s2 != s3) out_cnt <= out_cnt + 1;
  end

  task automatic model_clear();
    m_pend    = 4'b0000;
    m_ovf     = 4'b0000;
    m_id      = 2'd0;
    m_pulse   = 1'b0;
    m_busy    = 1'b0;
    m_rr      = 0;
    m_next_ok = 0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] req, input logic clr);
    logic [3:0] gm;
    logic [3:0] set;
    int         g;
    gm = 4'b0000;
    g  = -1;
    m_t++;
    if (en && m_pend != 4'b0000 && m_t >= m_next_ok) begin
      for (int k = 0; k < 4; k++)
        if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
    end
    m_pulse = (g >= 0);
    if (g >= 0) begin
      gm[g]     = 1'b1;
      m_id      = 2'(g);
      m_rr      = (g + 1) % 4;
      m_next_ok = m_t + P_GAP;
    end
    set    = req & m_pend & ~gm;
    m_ovf  = clr ? set : (m_ovf | set);
    m_pend = (m_pend & ~gm) | req;
    m_busy = (m_pend != 4'b0000) || (m_t < m_next_ok);
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle #1.
  task automatic cyc(input logic en, input logic [3:0] req, input logic clr);
    EN_I      = en;
    REQ_I     = req;
    CLR_OVF_I = clr;
    @(posedge CLK_I);
    if (XRST) model_clear();
    else      model_step(en, req, clr);
    #1;
    REQ_I     = 4'b0000;
    CLR_OVF_I = 1'b0;
  endtask

  task automatic do_reset();
    XRST = 1'b1;
    #1;
    model_clear();
    cyc(1'b1, 4'($urandom), 1'b0);
    cyc(1'b1, 4'($urandom), 1'b0);
    XRST = 1'b0;
  endtask

  task automatic drain(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!BUSY_O) begin
        ok = 1'b1;
        break;
      end
      cyc(1'b1, 4'b0000, 1'b0);
    end
  endtask

  task automatic test_reset();
    XRST = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      cyc(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
      n_total++;
      if ({PULSE_O, ID_O, PEND_O, OVF_O, BUSY_O} !== 12'd0)
        $display("FAIL reset_outputs: got %b expected 000000000000", {PULSE_O, ID_O, PEND_O, OVF_O, BUSY_O});
      else n_pass++;
    end
    XRST = 1'b0;
    cyc(1'b1, 4'b0000, 1'b0);
    n_total++;
    if ({PULSE_O, PEND_O, BUSY_O} !== 6'd0)
      $display("FAIL reset_release_idle: got %b expected 000000", {PULSE_O, PEND_O, BUSY_O});
    else n_pass++;
  endtask

  task automatic test_single();
    cyc(1'b1, 4'b0100, 1'b0);
    n_total++;
    if (PEND_O !== 4'b0100 || PULSE_O !== 1'b0)
      $display("FAIL single_pend: PEND_O=%b PULSE_O=%b expected 0100 0", PEND_O, PULSE_O);
    else n_pass++;
    cyc(1'b1, 4'b0000, 1'b0);
    n_total++;
    if (PULSE_O !== 1'b1 || ID_O !== 2'd2 || PEND_O !== 4'b0000)
      $display("FAIL single_grant: PULSE_O=%b ID_O=%0d PEND_O=%b expected 1 2 0000", PULSE_O, ID_O, PEND_O);
    else n_pass++;
    for (int k = 1; k < P_GAP; k++) begin
      cyc(1'b1, 4'b0000, 1'b0);
      n_total++;
      if ({BUSY_O, PULSE_O} !== 2'b10)
        $display("FAIL single_busy_gap: k=%0d BUSY_O=%b PULSE_O=%b expected 1 0", k, BUSY_O, PULSE_O);
      else n_pass++;
    end
    cyc(1'b1, 4'b0000, 1'b0);
    n_total++;
    if (BUSY_O !== 1'b0)
      $display("FAIL single_busy_end: BUSY_O=%b expected 0", BUSY_O);
    else n_pass++;
  endtask

  task automatic test_all_four();
    int p_time[4];
    int p_id[4];
    int np;
    np = 0;
    do_reset();
    cyc(1'b1, 4'b1111, 1'b0);
    for (int c = 1; c <= 4 * P_GAP + 4; c++) begin
      cyc(1'b1, 4'b0000, 1'b0);
      if (PULSE_O) begin
        if (np < 4) begin
          p_time[np] = c;
          p_id[np]   = int'(ID_O);
        end
        np++;
      end
    end
    n_total++;
    if (np !== 4) $display("FAIL all_four_count: got %0d pulses expected 4", np);
    else n_pass++;
    if (np >= 4) begin
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (p_id[i] !== i) $display("FAIL all_four_order: pulse %0d ID_O=%0d expected %0d", i, p_id[i], i);
        else n_pass++;
        if (i > 0) begin
          n_total++;
          if (p_time[i] - p_time[i-1] !== P_GAP)
            $display("FAIL all_four_spacing: pulse %0d gap=%0d expected %0d", i, p_time[i] - p_time[i-1], P_GAP);
          else n_pass++;
        end
      end
    end
    n_total++;
    if (BUSY_O !== 1'b0) $display("FAIL all_four_idle: BUSY_O=%b expected 0", BUSY_O);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int   g1;
    int   gall;
    logic ok;
    g1   = 0;
    gall = 0;
    cyc(1'b1, 4'b0001, 1'b0);
    cyc(1'b1, 4'b0010, 1'b0);
    n_total++;
    if (PULSE_O !== 1'b1 || ID_O !== 2'd0 || PEND_O !== 4'b0010 || OVF_O !== 4'b0000)
      $display("FAIL ovf_first: PULSE_O=%b ID_O=%0d PEND_O=%b OVF_O=%b expected 1 0 0010 0000", PULSE_O, ID_O, PEND_O, OVF_O);
    else n_pass++;
    cyc(1'b1, 4'b0010, 1'b0);
    n_total++;
    if (OVF_O !== 4'b0010 || PEND_O !== 4'b0010)
      $display("FAIL ovf_set: OVF_O=%b PEND_O=%b expected 0010 0010", OVF_O, PEND_O);
    else n_pass++;
    cyc(1'b1, 4'b0010, 1'b1);
    n_total++;
    if (OVF_O !== 4'b0010) $display("FAIL ovf_set_wins: OVF_O=%b expected 0010", OVF_O);
    else n_pass++;
    cyc(1'b1, 4'b0000, 1'b1);
    n_total++;
    if (OVF_O !== 4'b0000) $display("FAIL ovf_clear: OVF_O=%b expected 0000", OVF_O);
    else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!BUSY_O) begin
        ok = 1'b1;
        break;
      end
      cyc(1'b1, 4'b0000, 1'b0);
      if (PULSE_O) begin
        gall++;
        if (ID_O == 2'd1) g1++;
      end
    end
    n_total++;
    if (!ok || g1 !== 1 || gall !== 1)
      $display("FAIL ovf_single_grant: drained=%b grants_1=%0d grants=%0d expected 1 1 1", ok, g1, gall);
    else n_pass++;
  endtask

  task automatic test_coincident();
    logic ok;
    cyc(1'b1, 4'b1000, 1'b0);
    cyc(1'b1, 4'b1000, 1'b0);
    n_total++;
    if (PULSE_O !== 1'b1 || ID_O !== 2'd3 || PEND_O[3] !== 1'b1 || OVF_O[3] !== 1'b0)
      $display("FAIL coinc_grant: PULSE_O=%b ID_O=%0d PEND3=%b OVF3=%b expected 1 3 1 0", PULSE_O, ID_O, PEND_O[3], OVF_O[3]);
    else n_pass++;
    for (int k = 1; k <= P_GAP; k++) begin
      cyc(1'b1, 4'b0000, 1'b0);
      n_total++;
      if (PULSE_O !== (k == P_GAP))
        $display("FAIL coinc_spacing: k=%0d PULSE_O=%b expected %b", k, PULSE_O, (k == P_GAP));
      else n_pass++;
    end
    n_total++;
    if (ID_O !== 2'd3) $display("FAIL coinc_second_id: ID_O=%0d expected 3", ID_O);
    else n_pass++;
    drain(ok);
    n_total++;
    if (!ok) $display("FAIL coinc_drain: BUSY_O=%b expected 0 within bound", BUSY_O);
    else n_pass++;
  endtask

  task automatic test_enable();
    int first;
    do_reset();
    cyc(1'b0, 4'b0011, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 4'b0000, 1'b0);
      n_total++;
      if (PULSE_O !== 1'b0) $display("FAIL en_blocked: cycle %0d PULSE_O=%b expected 0", i, PULSE_O);
      else n_pass++;
    end
    n_total++;
    if (PEND_O !== 4'b0011 || BUSY_O !== 1'b1)
      $display("FAIL en_pending: PEND_O=%b BUSY_O=%b expected 0011 1", PEND_O, BUSY_O);
    else n_pass++;
    cyc(1'b1, 4'b0000, 1'b0);
    n_total++;
    if (PULSE_O !== 1'b1 || ID_O !== 2'd0)
      $display("FAIL en_first: PULSE_O=%b ID_O=%0d expected 1 0", PULSE_O, ID_O);
    else n_pass++;
    first = -1;
    for (int k = 1; k <= P_GAP + 2; k++) begin
      cyc(1'b1, 4'b0000, 1'b0);
      if (PULSE_O && first < 0) first = k;
    end
    n_total++;
    if (first !== P_GAP || ID_O !== 2'd1)
      $display("FAIL en_second: at=%0d ID_O=%0d expected %0d 1", first, ID_O, P_GAP);
    else n_pass++;
    // Mid-gap asynchronous reset.
    cyc(1'b1, 4'b0000, 1'b0);
    XRST = 1'b1;
    #1;
    model_clear();
    n_total++;
    if ({PULSE_O, ID_O, PEND_O, OVF_O, BUSY_O} !== 12'd0)
      $display("FAIL en_async_reset: got %b expected 000000000000", {PULSE_O, ID_O, PEND_O, OVF_O, BUSY_O});
    else n_pass++;
    cyc(1'b1, 4'b1111, 1'b0);
    XRST = 1'b0;
    cyc(1'b1, 4'b0000, 1'b0);
    n_total++;
    if (PEND_O !== 4'b0000 || PULSE_O !== 1'b0)
      $display("FAIL en_reset_discard: PEND_O=%b PULSE_O=%b expected 0000 0", PEND_O, PULSE_O);
    else n_pass++;
    cyc(1'b1, 4'b0100, 1'b0);
    n_total++;
    if (PEND_O !== 4'b0100 || PULSE_O !== 1'b0)
      $display("FAIL en_after_reset_pend: PEND_O=%b PULSE_O=%b expected 0100 0", PEND_O, PULSE_O);
    else n_pass++;
    cyc(1'b1, 4'b0000, 1'b0);
    n_total++;
    if (PULSE_O !== 1'b1 || ID_O !== 2'd2)
      $display("FAIL en_after_reset_grant: PULSE_O=%b ID_O=%0d expected 1 2", PULSE_O, ID_O);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       en;
    logic       clr;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 5) == 0);
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 15) == 0);
      cyc(en, r, clr);
      n_total++;
      if ({PULSE_O, ID_O, PEND_O, OVF_O, BUSY_O} !== {m_pulse, m_id, m_pend, m_ovf, m_busy})
        $display("FAIL random_model: cycle %0d pulse/id/pend/ovf/busy got %b %0d %b %b %b expected %b %0d %b %b %b",
                 i, PULSE_O, ID_O, PEND_O, OVF_O, BUSY_O, m_pulse, m_id, m_pend, m_ovf, m_busy);
      else n_pass++;
    end
  endtask

  task automatic test_crossing();
    int         g0;
    int         o0;
    logic       ok;
    logic [3:0] r;
    drain(ok);
    #400;
    g0 = grant_cnt;
    o0 = out_cnt;
    for (int i = 0; i < 300; i++) begin
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 2) == 0);
      cyc(1'b1, r, 1'b0);
    end
    drain(ok);
    n_total++;
    if (!ok) $display("FAIL cross_drain: BUSY_O=%b expected 0 within bound", BUSY_O);
    else n_pass++;
    #400;
    n_total++;
    if (grant_cnt - g0 < 30)
      $display("FAIL cross_activity: grants=%0d expected at least 30", grant_cnt - g0);
    else n_pass++;
    n_total++;
    if (out_cnt - o0 !== grant_cnt - g0)
      $display("FAIL cross_lossless: out pulses=%0d expected %0d", out_cnt - o0, grant_cnt - g0);
    else n_pass++;
  endtask

  initial begin
    XRST      = 1'b1;
    EN_I      = 1'b0;
    REQ_I     = 4'b0000;
    CLR_OVF_I = 1'b0;
    m_t       = 0;
    model_clear();
    test_reset();
    test_single();
    test_all_four();
    test_overflow();
    test_coincident();
    test_enable();
    test_random();
    test_crossing();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
